dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port mem_en, input, 1, MEM stage has a load/store this cycle.
REQ-004 SHALL have port mem_wr, input, 1, 1 = store, 0 = load.
REQ-005 SHALL have port mem_size, input, 2, 0 = byte, 1 = half, 2 = word.
REQ-006 SHALL have port mem_addr, input, 32, byte address from ALU.
REQ-007 SHALL have port mem_wdata, input, 32, lane-replicated store data from store-select logic.
REQ-008 SHALL have port addr_err, input, 1, load or store alignment error flagged by store-select logic.
REQ-009 SHALL have port flush, input, 1, exception flush of the MEM instruction.
REQ-010 SHALL have port pipe_stall, input, 1, stall from other sources; pipeline holds MEM.
REQ-011 SHALL have ports data_req (out, 1), data_wr (out, 1), data_size (out, 2), data_addr (out, 32), data_wdata (out, 32): SRAM-like request channel.
REQ-012 SHALL have ports data_addr_ok (in, 1), data_data_ok (in, 1), data_rdata (in, 32): SRAM-like response channel.
REQ-013 SHALL have port rdata, output, 32, raw read word to load-extract logic.
REQ-014 SHALL have port mem_stall, output, 1, 1 = hold pipeline, access pending.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: if mem_en & ~addr_err & ~flush, SHALL assert data_req combinationally in the same cycle, drive data_* from mem_* inputs, and go to REQ if ~data_addr_ok, or to WAIT if data_addr_ok.
REQ-017 IDLE with mem_en & (addr_err | flush) SHALL issue no request and SHALL keep mem_stall = 0.
REQ-018 REQ SHALL hold data_req = 1 with registered, stable data_wr/data_size/data_addr/data_wdata until data_addr_ok, then go to WAIT.
REQ-019 WAIT SHALL hold data_req = 0, and on data_data_ok SHALL latch data_rdata into rdata_r and go to DONE.
REQ-020 A data_data_ok in the same cycle as the accepting data_addr_ok SHALL be accepted only from WAIT, one cycle later; at most one transaction SHALL be outstanding.
REQ-021 mem_stall SHALL = 1 in IDLE when a request is issued, and in REQ and WAIT; it SHALL = 0 in DONE.
REQ-022 rdata SHALL = data_rdata combinationally in the data_data_ok cycle and rdata_r in DONE; otherwise it SHALL be 0.
REQ-023 DONE SHALL stay in DONE while pipe_stall = 1, issue no new request, and hold rdata; with pipe_stall = 0 it SHALL go to IDLE.
REQ-024 flush in REQ after acceptance, or in WAIT, SHALL NOT cancel the bus transaction; the FSM SHALL wait for data_data_ok, discard the data (rdata = 0), go to IDLE, and mem_stall SHALL = 0 from the flush cycle.
REQ-025 flush in REQ before acceptance SHALL keep data_req until data_addr_ok; the remainder of REQ-024 applies.
REQ-026 A flush-discarded transaction SHALL be tracked by a 1-bit drop flag cleared on its data_data_ok.

Reset
REQ-027 On rst the FSM SHALL go to IDLE and clear the drop flag.
REQ-028 On rst data_req SHALL = 0, mem_stall SHALL = 0, rdata_r SHALL = 0, and all registered data_* fields SHALL = 0.
REQ-029 rst mid-transaction SHALL abandon it; an interconnect reset on the same rst is required.

Configuration
REQ-030 With UNMAPPED_ADDR_XLATE_EN defined, data_addr SHALL = {3'b000, mem_addr[28:0]} for kseg0/kseg1 (mem_addr[31:30] = 2'b10); all other addresses SHALL pass unchanged.
REQ-031 Without UNMAPPED_ADDR_XLATE_EN, data_addr SHALL = mem_addr.

Verification
REQ-032 Load word: addr 0x8000_0010, addr_ok at cycle 0, data_ok at cycle 2 with 0x1234_5678 -> mem_stall high for cycles 0-1; rdata = 0x1234_5678 at cycle 2; data_addr = 0x0000_0010 with the macro defined.
REQ-033 Store byte with addr_ok delayed 3 cycles -> data_req held 4 cycles with data_wr = 1, size = 0, and wdata constant at 0xABAB_ABAB.
REQ-034 addr_err = 1 with mem_en = 1 -> data_req never asserted and mem_stall = 0.
REQ-035 flush in WAIT, then data_ok 2 cycles later -> mem_stall = 0 from the flush cycle, rdata = 0, FSM in IDLE after data_ok, and no new request before data_ok.
REQ-036 Load completes while pipe_stall = 1 for 3 cycles -> DONE held, rdata stable, and no second data_req.
REQ-037 rst asserted in REQ -> next cycle IDLE, data_req = 0, mem_stall = 0.

Source files
------------

// File: rtl/dmem_bridge.sv
// MEM-stage bridge from pipeline load/store to an SRAM-like data bus (IDLE/REQ/WAIT/DONE).
// Optional UNMAPPED_ADDR_XLATE_EN folds kseg0/kseg1 addresses to physical.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        addr_err,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdata,
  output logic        mem_stall
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        drop, drop_nxt;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic        issue, discard;

  function automatic logic [31:0] xlate(input logic [31:0] a);
`ifdef UNMAPPED_ADDR_XLATE_EN
    xlate = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
    xlate = a;
`endif
  endfunction

  assign issue   = (state == IDLE) && mem_en && !addr_err && !flush;
  // A flushed access still owes the bus its response; it is only the data that is thrown away.
  assign discard = drop || flush;

  assign data_wr    = issue ? mem_wr          : wr_r;
  assign data_size  = issue ? mem_size        : size_r;
  assign data_addr  = issue ? xlate(mem_addr) : addr_r;
  assign data_wdata = issue ? mem_wdata       : wdata_r;

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    data_req  = 1'b0;
    mem_stall = 1'b0;
    rdata     = '0;
    case (state)
      IDLE: begin
        if (issue) begin
          data_req  = 1'b1;
          mem_stall = 1'b1;
          state_nxt = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        data_req  = 1'b1;
        mem_stall = !discard;
        drop_nxt  = discard;
        if (data_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        if (data_data_ok) begin
          drop_nxt = 1'b0;
          if (discard) begin
            state_nxt = IDLE;
          end else begin
            rdata     = data_rdata;
            state_nxt = DONE;
          end
        end else begin
          mem_stall = !discard;
          drop_nxt  = discard;
        end
      end
      DONE: begin
        rdata = rdata_r;
        if (!pipe_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      drop    <= 1'b0;
      wr_r    <= 1'b0;
      size_r  <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (issue) begin
        wr_r    <= mem_wr;
        size_r  <= mem_size;
        addr_r  <= xlate(mem_addr);
        wdata_r <= mem_wdata;
      end
      if (state == WAIT && data_data_ok && !discard) rdata_r <= data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge: load/store handshakes, error, flush, stall, reset.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst, mem_en, mem_wr, addr_err, flush, pipe_stall;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, rdata;
  logic        mem_stall;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_bridge dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .addr_err(addr_err), .flush(flush), .pipe_stall(pipe_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .rdata(rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr1;

  initial begin
`ifdef UNMAPPED_ADDR_XLATE_EN
    exp_addr1 = 32'h0000_0010;
`else
    exp_addr1 = 32'h8000_0010;
`endif
    rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    addr_err = 1'b0; flush = 1'b0; pipe_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h9999_9999;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_req", {31'b0, data_req}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);

    // load word, addr_ok immediately, data_ok two cycles later
    tick();
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h8000_0010; data_addr_ok = 1'b1; #1;
    chk("lw_c0_req", {31'b0, data_req}, 32'd1);
    chk("lw_c0_stall", {31'b0, mem_stall}, 32'd1);
    chk("lw_c0_addr", data_addr, exp_addr1);
    chk("lw_c0_size", {30'b0, data_size}, 32'd2);
    tick();
    data_addr_ok = 1'b0; #1;
    chk("lw_c1_req", {31'b0, data_req}, 32'd0);
    chk("lw_c1_stall", {31'b0, mem_stall}, 32'd1);
    chk("lw_c1_rdata", rdata, 32'd0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678; #1;
    chk("lw_c2_rdata", rdata, 32'h1234_5678);
    chk("lw_c2_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h5555_5555; mem_en = 1'b0; #1;
    chk("lw_done_rdata", rdata, 32'h1234_5678);
    chk("lw_done_stall", {31'b0, mem_stall}, 32'd0);
    tick(); #1;
    chk("lw_idle_rdata", rdata, 32'd0);

    // store byte, addr_ok delayed 3 cycles; inputs change after issue to prove registered hold
    mem_en = 1'b1; mem_wr = 1'b1; mem_size = 2'd0; mem_addr = 32'h0000_0103; mem_wdata = 32'hABAB_ABAB; #1;
    chk("sb_c0_req", {31'b0, data_req}, 32'd1);
    chk("sb_c0_wr", {31'b0, data_wr}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      mem_wdata = 32'h1111_1111; mem_size = 2'd2; mem_wr = 1'b0;
      data_addr_ok = (i == 3); #1;
      chk("sb_hold_req", {31'b0, data_req}, 32'd1);
      chk("sb_hold_wr", {31'b0, data_wr}, 32'd1);
      chk("sb_hold_size", {30'b0, data_size}, 32'd0);
      chk("sb_hold_wdata", data_wdata, 32'hABAB_ABAB);
      chk("sb_hold_addr", data_addr, 32'h0000_0103);
      chk("sb_hold_stall", {31'b0, mem_stall}, 32'd1);
    end
    tick();
    data_addr_ok = 1'b0; #1;
    chk("sb_wait_req", {31'b0, data_req}, 32'd0);
    chk("sb_wait_stall", {31'b0, mem_stall}, 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'd0; #1;
    chk("sb_ack_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    data_data_ok = 1'b0; mem_en = 1'b0; tick();

    // alignment error: no request, no stall
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_0002; addr_err = 1'b1; data_addr_ok = 1'b1; #1;
    chk("aerr_req", {31'b0, data_req}, 32'd0);
    chk("aerr_stall", {31'b0, mem_stall}, 32'd0);
    tick(); #1;
    chk("aerr_req2", {31'b0, data_req}, 32'd0);
    addr_err = 1'b0; mem_en = 1'b0; data_addr_ok = 1'b0;
    tick();

    // flush in WAIT, data_ok two cycles later is discarded
    mem_en = 1'b1; mem_addr = 32'h0000_0040; data_addr_ok = 1'b1; #1;
    chk("fw_issue", {31'b0, data_req}, 32'd1);
    tick();
    data_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("fw_flush_stall", {31'b0, mem_stall}, 32'd0);
    chk("fw_flush_req", {31'b0, data_req}, 32'd0);
    tick();
    flush = 1'b0; mem_addr = 32'h0000_0080; data_addr_ok = 1'b1; #1;
    chk("fw_norenew_req", {31'b0, data_req}, 32'd0);
    chk("fw_after_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    data_addr_ok = 1'b0; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #1;
    chk("fw_dok_rdata", rdata, 32'd0);
    chk("fw_dok_req", {31'b0, data_req}, 32'd0);
    tick();
    data_data_ok = 1'b0; #1;
    chk("fw_idle_rdata", rdata, 32'd0);

    // load completes while pipe_stall holds DONE for 3 cycles
    mem_en = 1'b1; mem_addr = 32'h0000_0020; pipe_stall = 1'b1; data_addr_ok = 1'b1; #1;
    chk("ps_issue_req", {31'b0, data_req}, 32'd1);
    chk("ps_issue_addr", data_addr, 32'h0000_0020);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; #1;
    chk("ps_dok_rdata", rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h5555_5555; data_addr_ok = 1'b1; #1;
      chk("ps_done_rdata", rdata, 32'hCAFE_F00D);
      chk("ps_done_req", {31'b0, data_req}, 32'd0);
      chk("ps_done_stall", {31'b0, mem_stall}, 32'd0);
    end
    pipe_stall = 1'b0; #1;
    chk("ps_release_rdata", rdata, 32'hCAFE_F00D);
    tick();
    mem_en = 1'b0; data_addr_ok = 1'b0; #1;
    chk("ps_idle_rdata", rdata, 32'd0);

    // reset while in REQ
    tick();
    mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'h0F0F_0F0F; #1;
    tick(); #1;
    chk("rr_req_before", {31'b0, data_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_en = 1'b0; #1;
    chk("rr_req", {31'b0, data_req}, 32'd0);
    chk("rr_stall", {31'b0, mem_stall}, 32'd0);
    chk("rr_addr", data_addr, 32'd0);
    chk("rr_wr", {31'b0, data_wr}, 32'd0);

    // flush in REQ before acceptance: request held, data discarded
    tick();
    mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_0300; #1;
    tick();
    flush = 1'b1; #1;
    chk("fr_flush_req", {31'b0, data_req}, 32'd1);
    chk("fr_flush_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    flush = 1'b0; mem_en = 1'b0; data_addr_ok = 1'b1; #1;
    chk("fr_held_req", {31'b0, data_req}, 32'd1);
    chk("fr_held_stall", {31'b0, mem_stall}, 32'd0);
    chk("fr_held_addr", data_addr, 32'h0000_0300);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777; #1;
    chk("fr_dok_rdata", rdata, 32'd0);
    tick();
    data_data_ok = 1'b0; mem_en = 1'b1; mem_addr = 32'h0000_0400; #1;
    chk("fr_idle_issue_req", {31'b0, data_req}, 32'd1);
    chk("fr_idle_issue_stall", {31'b0, mem_stall}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
